// File: rtl/aibndaux_actred_pkg.sv
// Shared definitions for the AIB aux active-redundancy chain (TX serializer and RX decoder).
package aibndaux_actred_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } actred_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/aibndaux_actred_tx_bitclk.sv
// Bit-period divider: counts 0..DIV-1 while enabled and pulses bit_tick on the last count.
module aibndaux_actred_tx_bitclk #(
  parameter int DIV = 4
) (
  input  logic actred_clk,
  input  logic actred_rst,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = en & (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || bit_tick) cnt_d = '0;
    else if (en)         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge actred_clk or posedge actred_rst) begin
    if (actred_rst) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aibndaux_actred_tx.sv
// Active-redundancy chain serializer: start, NBITS data (LSB first), optional parity, stop.
// Parity bit is present only when AIBNDAUX_ACTRED_TX_PARITY_EN is defined.
module aibndaux_actred_tx
  import aibndaux_actred_pkg::*;
#(
  parameter int NBITS = 24,
  parameter int DIV   = 4
) (
  input  logic             actred_clk,
  input  logic             actred_rst,
  input  logic [NBITS-1:0] actred_tx_data,
  input  logic             actred_tx_valid,
  output logic             actred_tx_ready,
  input  logic             actred_tx_abort,
  output logic             actred_tx_done,
  output logic             actred_tx_busy,
  output logic             actred_chain1_tx,
  output logic             actred_chain2_tx,
  output logic             actred_txen
);

  localparam int BW = $clog2(NBITS + 1);

  actred_state_e    state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             line_q, line_d;
  logic             done_q, done_d;
  logic             txen_q;
  logic             accept, bit_tick;
`ifdef AIBNDAUX_ACTRED_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign actred_tx_ready  = (state_q == ST_IDLE) & ~actred_tx_abort;
  assign actred_tx_busy   = (state_q != ST_IDLE);
  assign accept           = actred_tx_valid & actred_tx_ready;
  assign actred_tx_done   = done_q;
  assign actred_chain1_tx = line_q;
  assign actred_chain2_tx = line_q;
  assign actred_txen      = txen_q;

  aibndaux_actred_tx_bitclk #(.DIV(DIV)) u_bitclk (
    .actred_clk (actred_clk),
    .actred_rst (actred_rst),
    .clr        (actred_tx_abort | accept),
    .en         (actred_tx_busy),
    .bit_tick   (bit_tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    done_d   = 1'b0;
    line_d   = IDLE_LEVEL;
`ifdef AIBNDAUX_ACTRED_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_START;
          shreg_d  = actred_tx_data;
          bitcnt_d = '0;
`ifdef AIBNDAUX_ACTRED_TX_PARITY_EN
          par_d    = ^actred_tx_data;
`endif
        end
      end
      ST_START: begin
        line_d = START_BIT;
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        line_d = shreg_q[0];
        if (bit_tick) begin
          shreg_d = shreg_q >> 1;
          if (bitcnt_q == BW'(NBITS - 1)) begin
            bitcnt_d = '0;
`ifdef AIBNDAUX_ACTRED_TX_PARITY_EN
            state_d  = ST_PAR;
`else
            state_d  = ST_STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
`ifdef AIBNDAUX_ACTRED_TX_PARITY_EN
      ST_PAR: begin
        line_d = par_q;
        if (bit_tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        line_d = STOP_BIT;
        if (bit_tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over everything: line back to idle level next cycle, no done.
    if (actred_tx_abort) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      done_d   = 1'b0;
      line_d   = IDLE_LEVEL;
    end
  end

  always_ff @(posedge actred_clk or posedge actred_rst) begin
    if (actred_rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      line_q   <= IDLE_LEVEL;
      done_q   <= 1'b0;
      txen_q   <= 1'b0;
`ifdef AIBNDAUX_ACTRED_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      line_q   <= line_d;
      done_q   <= done_d;
      txen_q   <= 1'b1;
`ifdef AIBNDAUX_ACTRED_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule
